// File: rtl/hls_activity_monitor.sv
// Passive activity monitor for an HLS ap_ctrl handshake and one pipelined loop FSM.
// Counts transactions, latencies, iterations, stalls and occupancy; freezes on finish.
module hls_activity_monitor #(
  parameter int unsigned STATE_W = 26,
  parameter int unsigned CNT_W   = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               finish,
  input  logic               ap_start,
  input  logic               ap_ready,
  input  logic               ap_done,
  input  logic               ap_continue,
  input  logic [STATE_W-1:0] cur_state,
  input  logic [STATE_W-1:0] iter_start_state,
  input  logic [STATE_W-1:0] iter_end_state,
  input  logic [STATE_W-1:0] quit_state,
  input  logic               iter_start_block,
  input  logic               iter_end_block,
  input  logic               quit_block,
  input  logic               iter_start_enable,
  input  logic               iter_end_enable,
  input  logic               quit_enable,
  input  logic               loop_start,
  input  logic               loop_ready,
  input  logic               loop_done,
  input  logic               loop_continue,
  input  logic               quit_at_end,
  output logic               mod_busy,
  output logic [CNT_W-1:0]   mod_start_cnt,
  output logic [CNT_W-1:0]   mod_done_cnt,
  output logic [CNT_W-1:0]   mod_busy_cycles,
  output logic [CNT_W-1:0]   mod_last_lat,
  output logic [CNT_W-1:0]   mod_max_lat,
  output logic               loop_active,
  output logic [CNT_W-1:0]   loop_inv_cnt,
  output logic [CNT_W-1:0]   iter_start_cnt,
  output logic [CNT_W-1:0]   iter_end_cnt,
  output logic [CNT_W-1:0]   stall_cycles,
  output logic [CNT_W-1:0]   in_flight,
  output logic [CNT_W-1:0]   max_in_flight,
  output logic [CNT_W-1:0]   last_ii,
  output logic               frozen
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {M_IDLE, M_BUSY, M_WAIT} mod_state_t;
  typedef enum logic {L_IDLE, L_RUN} loop_state_t;

  mod_state_t  mod_state, mod_state_nxt;
  loop_state_t loop_state, loop_state_nxt;

  logic             mod_launch, loop_launch, loop_win;
  logic             st, en, qt, stall;
  logic             qt_seen, st_seen;
  logic [CNT_W-1:0] mod_lat, done_lat, since_st, in_flight_base, in_flight_nxt;

  // Saturating increment shared by every counter
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  // State registers; both FSMs hold while frozen
  always_ff @(posedge clock) begin
    if (!reset) begin
      mod_state  <= M_IDLE;
      loop_state <= L_IDLE;
    end else if (!frozen) begin
      mod_state  <= mod_state_nxt;
      loop_state <= loop_state_nxt;
    end
  end

  // Next-state logic; a start in a returning-to-idle cycle keeps the module busy
  always_comb begin
    mod_state_nxt  = mod_state;
    loop_state_nxt = loop_state;
    mod_launch     = 1'b0;
    case (mod_state)
      M_IDLE: if (ap_start) begin
        mod_state_nxt = M_BUSY;
        mod_launch    = 1'b1;
      end
      M_BUSY: if (ap_done) begin
        if (!ap_continue)  mod_state_nxt = M_WAIT;
        else if (ap_start) mod_launch    = 1'b1;
        else               mod_state_nxt = M_IDLE;
      end
      M_WAIT: if (ap_continue) begin
        mod_state_nxt = ap_start ? M_BUSY : M_IDLE;
        mod_launch    = ap_start;
      end
      default: mod_state_nxt = M_IDLE;
    endcase
    case (loop_state)
      L_IDLE: if (loop_start) loop_state_nxt = L_RUN;
      L_RUN:  if (loop_done && loop_continue && (!quit_at_end || qt_seen || qt))
        loop_state_nxt = L_IDLE;
      default: loop_state_nxt = L_IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    mod_busy    = (mod_state != M_IDLE);
    loop_active = (loop_state == L_RUN);
  end

  // Loop event decode and occupancy update
  always_comb begin
    st          = (cur_state == iter_start_state) && iter_start_enable && !iter_start_block;
    en          = (cur_state == iter_end_state) && iter_end_enable && !iter_end_block;
    qt          = (cur_state == quit_state) && quit_enable && !quit_block;
    stall       = loop_active && (cur_state == iter_start_state) && iter_start_enable
                  && iter_start_block;
    loop_launch = (loop_state == L_IDLE) && loop_start;
    loop_win    = loop_active || loop_launch;
    done_lat    = sat_inc(mod_lat);
    in_flight_base = loop_launch ? '0 : in_flight;
    in_flight_nxt  = in_flight_base;
    if (st && !en)
      in_flight_nxt = sat_inc(in_flight_base);
    else if (en && !st && (in_flight_base != '0))
      in_flight_nxt = in_flight_base - CNT_W'(1);
  end

  // Statistics registers
  always_ff @(posedge clock) begin
    if (!reset) begin
      frozen          <= 1'b0;
      mod_start_cnt   <= '0;
      mod_done_cnt    <= '0;
      mod_busy_cycles <= '0;
      mod_last_lat    <= '0;
      mod_max_lat     <= '0;
      mod_lat         <= '0;
      loop_inv_cnt    <= '0;
      iter_start_cnt  <= '0;
      iter_end_cnt    <= '0;
      stall_cycles    <= '0;
      in_flight       <= '0;
      max_in_flight   <= '0;
      last_ii         <= '0;
      since_st        <= '0;
      qt_seen         <= 1'b0;
      st_seen         <= 1'b0;
    end else if (!frozen) begin
      frozen <= finish;
      if (ap_start && ap_ready) mod_start_cnt   <= sat_inc(mod_start_cnt);
      if (ap_done && ap_continue) mod_done_cnt  <= sat_inc(mod_done_cnt);
      if (mod_busy)             mod_busy_cycles <= sat_inc(mod_busy_cycles);
      if (mod_launch)                  mod_lat <= '0;
      else if (mod_state == M_BUSY)    mod_lat <= sat_inc(mod_lat);
      if ((mod_state == M_BUSY) && ap_done) begin
        mod_last_lat <= done_lat;
        if (done_lat > mod_max_lat) mod_max_lat <= done_lat;
      end
      if (loop_launch) loop_inv_cnt <= sat_inc(loop_inv_cnt);
      if (stall)       stall_cycles <= sat_inc(stall_cycles);
      if (loop_win) begin
        if (st) iter_start_cnt <= sat_inc(iter_start_cnt);
        if (en) iter_end_cnt   <= sat_inc(iter_end_cnt);
        in_flight <= in_flight_nxt;
        if (in_flight_nxt > max_in_flight) max_in_flight <= in_flight_nxt;
        qt_seen  <= (qt_seen && !loop_launch) || qt;
        st_seen  <= (st_seen && !loop_launch) || st;
        since_st <= st ? CNT_W'(1) : sat_inc(since_st);
        // The first start of an invocation has no predecessor to measure from
        if (st && st_seen && !loop_launch) last_ii <= since_st;
      end
    end
  end

  logic unused_ok;
  assign unused_ok = loop_ready;

endmodule

// File: tb/tb_hls_activity_monitor.sv
// Directed bench for hls_activity_monitor: handshake, loop, stall, freeze, reset, saturation.
module tb_hls_activity_monitor;
  localparam int unsigned STATE_W = 26;
  localparam int unsigned CNT_W   = 32;
  localparam logic [STATE_W-1:0] S = 26'd42;

  logic clock = 1'b0, reset, finish;
  logic ap_start, ap_ready, ap_done, ap_continue;
  logic [STATE_W-1:0] cur_state, iter_start_state, iter_end_state, quit_state;
  logic iter_start_block, iter_end_block, quit_block;
  logic iter_start_enable, iter_end_enable, quit_enable;
  logic loop_start, loop_ready, loop_done, loop_continue, quit_at_end;

  logic mod_busy, loop_active, frozen;
  logic [CNT_W-1:0] mod_start_cnt, mod_done_cnt, mod_busy_cycles, mod_last_lat, mod_max_lat;
  logic [CNT_W-1:0] loop_inv_cnt, iter_start_cnt, iter_end_cnt, stall_cycles;
  logic [CNT_W-1:0] in_flight, max_in_flight, last_ii;

  logic s_busy, s_active, s_frozen;
  logic [2:0] s_start, s_done, s_busy_cyc, s_last_lat, s_max_lat, s_inv, s_ist, s_ien;
  logic [2:0] s_stall, s_inf, s_max_inf, s_ii;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clock = ~clock;

  hls_activity_monitor #(.STATE_W(STATE_W), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .finish(finish),
    .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done), .ap_continue(ap_continue),
    .cur_state(cur_state), .iter_start_state(iter_start_state),
    .iter_end_state(iter_end_state), .quit_state(quit_state),
    .iter_start_block(iter_start_block), .iter_end_block(iter_end_block),
    .quit_block(quit_block), .iter_start_enable(iter_start_enable),
    .iter_end_enable(iter_end_enable), .quit_enable(quit_enable),
    .loop_start(loop_start), .loop_ready(loop_ready), .loop_done(loop_done),
    .loop_continue(loop_continue), .quit_at_end(quit_at_end),
    .mod_busy(mod_busy), .mod_start_cnt(mod_start_cnt), .mod_done_cnt(mod_done_cnt),
    .mod_busy_cycles(mod_busy_cycles), .mod_last_lat(mod_last_lat), .mod_max_lat(mod_max_lat),
    .loop_active(loop_active), .loop_inv_cnt(loop_inv_cnt), .iter_start_cnt(iter_start_cnt),
    .iter_end_cnt(iter_end_cnt), .stall_cycles(stall_cycles), .in_flight(in_flight),
    .max_in_flight(max_in_flight), .last_ii(last_ii), .frozen(frozen)
  );

  // Narrow instance so counter saturation is reachable in a short run
  hls_activity_monitor #(.STATE_W(STATE_W), .CNT_W(3)) dut_s (
    .clock(clock), .reset(reset), .finish(finish),
    .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done), .ap_continue(ap_continue),
    .cur_state(cur_state), .iter_start_state(iter_start_state),
    .iter_end_state(iter_end_state), .quit_state(quit_state),
    .iter_start_block(iter_start_block), .iter_end_block(iter_end_block),
    .quit_block(quit_block), .iter_start_enable(iter_start_enable),
    .iter_end_enable(iter_end_enable), .quit_enable(quit_enable),
    .loop_start(loop_start), .loop_ready(loop_ready), .loop_done(loop_done),
    .loop_continue(loop_continue), .quit_at_end(quit_at_end),
    .mod_busy(s_busy), .mod_start_cnt(s_start), .mod_done_cnt(s_done),
    .mod_busy_cycles(s_busy_cyc), .mod_last_lat(s_last_lat), .mod_max_lat(s_max_lat),
    .loop_active(s_active), .loop_inv_cnt(s_inv), .iter_start_cnt(s_ist),
    .iter_end_cnt(s_ien), .stall_cycles(s_stall), .in_flight(s_inf),
    .max_in_flight(s_max_inf), .last_ii(s_ii), .frozen(s_frozen)
  );

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic clear_inputs();
    finish = 0; ap_start = 0; ap_ready = 0; ap_done = 0; ap_continue = 0;
    cur_state = S; iter_start_state = S; iter_end_state = S; quit_state = S;
    iter_start_block = 0; iter_end_block = 0; quit_block = 0;
    iter_start_enable = 0; iter_end_enable = 0; quit_enable = 0;
    loop_start = 0; loop_ready = 0; loop_done = 0; loop_continue = 0; quit_at_end = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 0;
    tick(2);
    reset = 1;
    if ({mod_busy, loop_active, frozen} !== 3'b000) begin
      err_cnt++; $display("FAIL reset_flags: got %b want 000", {mod_busy, loop_active, frozen});
    end
    vec_cnt++;
    if ((mod_start_cnt | mod_done_cnt | mod_busy_cycles | mod_last_lat | mod_max_lat |
         loop_inv_cnt | iter_start_cnt | iter_end_cnt | stall_cycles | in_flight |
         max_in_flight | last_ii) !== '0) begin
      err_cnt++; $display("FAIL reset_counters: some counter nonzero (or=%0h)",
        mod_start_cnt | mod_done_cnt | mod_busy_cycles | mod_last_lat | mod_max_lat |
        loop_inv_cnt | iter_start_cnt | iter_end_cnt | stall_cycles | in_flight |
        max_in_flight | last_ii);
    end
    vec_cnt++;
  endtask

  task automatic single_call();
    ap_start = 1; ap_ready = 1;
    tick();
    ap_start = 0; ap_ready = 0;
    tick(4);
    ap_done = 1; ap_continue = 1;
    tick();
    ap_done = 0; ap_continue = 0;
  endtask

  task automatic test_single_call();
    single_call();
    if (mod_busy !== 1'b0) begin err_cnt++; $display("FAIL single_busy: got %b want 0", mod_busy); end
    vec_cnt++;
    if (mod_start_cnt !== 1) begin err_cnt++; $display("FAIL single_start: got %0d want 1", mod_start_cnt); end
    vec_cnt++;
    if (mod_done_cnt !== 1) begin err_cnt++; $display("FAIL single_done: got %0d want 1", mod_done_cnt); end
    vec_cnt++;
    if (mod_last_lat !== 5) begin err_cnt++; $display("FAIL single_lat: got %0d want 5", mod_last_lat); end
    vec_cnt++;
    if (mod_busy_cycles !== 5) begin err_cnt++; $display("FAIL single_busycyc: got %0d want 5", mod_busy_cycles); end
    vec_cnt++;
    if (mod_max_lat !== 5) begin err_cnt++; $display("FAIL single_maxlat: got %0d want 5", mod_max_lat); end
    vec_cnt++;
  endtask

  task automatic test_backpressure();
    ap_start = 1; ap_ready = 1;
    tick();
    ap_start = 0; ap_ready = 0;
    tick(2);
    ap_done = 1; ap_continue = 0;
    tick();
    if (mod_busy !== 1'b1) begin err_cnt++; $display("FAIL bp_wait_busy: got %b want 1", mod_busy); end
    vec_cnt++;
    if (mod_last_lat !== 3) begin err_cnt++; $display("FAIL bp_lat: got %0d want 3", mod_last_lat); end
    vec_cnt++;
    tick(2);
    if (mod_done_cnt !== 1) begin err_cnt++; $display("FAIL bp_done_held: got %0d want 1", mod_done_cnt); end
    vec_cnt++;
    if (mod_last_lat !== 3) begin err_cnt++; $display("FAIL bp_lat_held: got %0d want 3", mod_last_lat); end
    vec_cnt++;
    ap_continue = 1;
    tick();
    ap_done = 0; ap_continue = 0;
    if (mod_busy !== 1'b0) begin err_cnt++; $display("FAIL bp_idle: got %b want 0", mod_busy); end
    vec_cnt++;
    if (mod_done_cnt !== 2) begin err_cnt++; $display("FAIL bp_done: got %0d want 2", mod_done_cnt); end
    vec_cnt++;
    if (mod_busy_cycles !== 11) begin err_cnt++; $display("FAIL bp_busycyc: got %0d want 11", mod_busy_cycles); end
    vec_cnt++;
  endtask

  task automatic test_back_to_back();
    ap_start = 1; ap_ready = 1;
    tick();
    ap_start = 0; ap_ready = 0;
    tick();
    ap_start = 1; ap_ready = 1; ap_done = 1; ap_continue = 1;
    tick();
    ap_start = 0; ap_ready = 0; ap_done = 0; ap_continue = 0;
    if (mod_busy !== 1'b1) begin err_cnt++; $display("FAIL b2b_stay_busy: got %b want 1", mod_busy); end
    vec_cnt++;
    if (mod_last_lat !== 2) begin err_cnt++; $display("FAIL b2b_lat1: got %0d want 2", mod_last_lat); end
    vec_cnt++;
    tick();
    ap_done = 1; ap_continue = 1;
    tick();
    ap_done = 0; ap_continue = 0;
    if (mod_last_lat !== 2) begin err_cnt++; $display("FAIL b2b_lat2: got %0d want 2", mod_last_lat); end
    vec_cnt++;
    if ({mod_start_cnt, mod_done_cnt} !== {32'd4, 32'd4}) begin
      err_cnt++; $display("FAIL b2b_counts: got %0d/%0d want 4/4", mod_start_cnt, mod_done_cnt);
    end
    vec_cnt++;
    if (mod_busy_cycles !== 15) begin err_cnt++; $display("FAIL b2b_busycyc: got %0d want 15", mod_busy_cycles); end
    vec_cnt++;
    if (mod_max_lat !== 5) begin err_cnt++; $display("FAIL b2b_maxlat: got %0d want 5", mod_max_lat); end
    vec_cnt++;
  endtask

  task automatic test_loop();
    quit_at_end = 1;
    loop_start = 1;
    tick();
    loop_start = 0;
    for (int c = 1; c <= 8; c++) begin
      iter_start_enable = (c <= 4);
      iter_end_enable   = (c >= 5);
      quit_enable       = (c == 8);
      loop_done         = (c == 8);
      loop_continue     = (c == 8);
      tick();
      if (c == 4) begin
        if (in_flight !== 4) begin err_cnt++; $display("FAIL loop_inflight_peak: got %0d want 4", in_flight); end
        vec_cnt++;
      end
    end
    iter_end_enable = 0; quit_enable = 0; loop_done = 0; loop_continue = 0;
    if (loop_active !== 1'b0) begin err_cnt++; $display("FAIL loop_exit: got %b want 0", loop_active); end
    vec_cnt++;
    if ({iter_start_cnt, iter_end_cnt} !== {32'd4, 32'd4}) begin
      err_cnt++; $display("FAIL loop_iters: got %0d/%0d want 4/4", iter_start_cnt, iter_end_cnt);
    end
    vec_cnt++;
    if (max_in_flight !== 4) begin err_cnt++; $display("FAIL loop_max_inflight: got %0d want 4", max_in_flight); end
    vec_cnt++;
    if (last_ii !== 1) begin err_cnt++; $display("FAIL loop_ii: got %0d want 1", last_ii); end
    vec_cnt++;
    if (in_flight !== 0) begin err_cnt++; $display("FAIL loop_inflight_end: got %0d want 0", in_flight); end
    vec_cnt++;
    if (loop_inv_cnt !== 1) begin err_cnt++; $display("FAIL loop_inv: got %0d want 1", loop_inv_cnt); end
    vec_cnt++;
  endtask

  task automatic test_quit_at_end();
    loop_start = 1;
    tick();
    loop_start = 0;
    loop_done = 1; loop_continue = 1; iter_end_enable = 1;
    tick();
    iter_end_enable = 0;
    if (loop_active !== 1'b1) begin err_cnt++; $display("FAIL qae_no_quit: got %b want 1", loop_active); end
    vec_cnt++;
    if (in_flight !== 0) begin err_cnt++; $display("FAIL qae_underflow: got %0d want 0", in_flight); end
    vec_cnt++;
    if (iter_end_cnt !== 5) begin err_cnt++; $display("FAIL qae_end_cnt: got %0d want 5", iter_end_cnt); end
    vec_cnt++;
    quit_enable = 1;
    tick();
    quit_enable = 0; loop_done = 0; loop_continue = 0;
    if (loop_active !== 1'b0) begin err_cnt++; $display("FAIL qae_quit: got %b want 0", loop_active); end
    vec_cnt++;
  endtask

  task automatic test_stall();
    quit_at_end = 0;
    loop_start = 1;
    tick();
    loop_start = 0;
    iter_start_enable = 1;
    tick();
    iter_start_block = 1;
    tick(3);
    iter_start_block = 0;
    tick();
    iter_start_enable = 0;
    if (stall_cycles !== 3) begin err_cnt++; $display("FAIL stall_cnt: got %0d want 3", stall_cycles); end
    vec_cnt++;
    if (last_ii !== 4) begin err_cnt++; $display("FAIL stall_ii: got %0d want 4", last_ii); end
    vec_cnt++;
    if (in_flight !== 2) begin err_cnt++; $display("FAIL stall_inflight: got %0d want 2", in_flight); end
    vec_cnt++;
    iter_end_enable = 1;
    tick(2);
    iter_end_enable = 0; loop_done = 1; loop_continue = 1;
    tick();
    loop_done = 0; loop_continue = 0;
    if ({iter_start_cnt, iter_end_cnt} !== {32'd6, 32'd7}) begin
      err_cnt++; $display("FAIL stall_iters: got %0d/%0d want 6/7", iter_start_cnt, iter_end_cnt);
    end
    vec_cnt++;
    if (loop_active !== 1'b0) begin err_cnt++; $display("FAIL stall_exit: got %b want 0", loop_active); end
    vec_cnt++;
  endtask

  task automatic test_freeze();
    loop_start = 1;
    tick();
    loop_start = 0; iter_start_enable = 1;
    tick();
    finish = 1;
    tick();
    finish = 0;
    ap_start = 1; ap_ready = 1; loop_done = 1; loop_continue = 1; quit_enable = 1;
    for (int i = 0; i < 10; i++) begin
      iter_end_enable = i[0];
      iter_start_block = (i == 3);
      tick();
    end
    clear_inputs();
    if (frozen !== 1'b1) begin err_cnt++; $display("FAIL frz_flag: got %b want 1", frozen); end
    vec_cnt++;
    if (iter_start_cnt !== 8) begin err_cnt++; $display("FAIL frz_ist: got %0d want 8", iter_start_cnt); end
    vec_cnt++;
    if (in_flight !== 2) begin err_cnt++; $display("FAIL frz_inflight: got %0d want 2", in_flight); end
    vec_cnt++;
    if ({mod_start_cnt, mod_busy_cycles, iter_end_cnt} !== {32'd4, 32'd15, 32'd7}) begin
      err_cnt++; $display("FAIL frz_counts: got %0d/%0d/%0d want 4/15/7",
        mod_start_cnt, mod_busy_cycles, iter_end_cnt);
    end
    vec_cnt++;
    if ({mod_busy, loop_active} !== 2'b01) begin
      err_cnt++; $display("FAIL frz_fsm: got %b want 01", {mod_busy, loop_active});
    end
    vec_cnt++;
    if ({loop_inv_cnt, stall_cycles} !== {32'd4, 32'd3}) begin
      err_cnt++; $display("FAIL frz_inv_stall: got %0d/%0d want 4/3", loop_inv_cnt, stall_cycles);
    end
    vec_cnt++;
  endtask

  task automatic test_reset_mid_op();
    reset = 0;
    tick();
    reset = 1;
    ap_start = 1; ap_ready = 1; loop_start = 1; iter_start_enable = 1;
    tick();
    ap_start = 0; ap_ready = 0; loop_start = 0;
    tick(2);
    reset = 0;
    tick();
    reset = 1;
    iter_start_enable = 0;
    if ({mod_busy, loop_active, frozen} !== 3'b000) begin
      err_cnt++; $display("FAIL rst_mid_flags: got %b want 000", {mod_busy, loop_active, frozen});
    end
    vec_cnt++;
    if ((mod_start_cnt | mod_busy_cycles | loop_inv_cnt | iter_start_cnt | in_flight |
         max_in_flight | last_ii) !== '0) begin
      err_cnt++; $display("FAIL rst_mid_counters: got start=%0d ist=%0d inf=%0d want 0",
        mod_start_cnt, iter_start_cnt, in_flight);
    end
    vec_cnt++;
    single_call();
    if ({mod_start_cnt, mod_done_cnt, mod_last_lat} !== {32'd1, 32'd1, 32'd5}) begin
      err_cnt++; $display("FAIL rst_rerun: got %0d/%0d/%0d want 1/1/5",
        mod_start_cnt, mod_done_cnt, mod_last_lat);
    end
    vec_cnt++;
  endtask

  task automatic test_saturation();
    ap_start = 1; ap_ready = 1;
    tick(20);
    ap_start = 0; ap_ready = 0;
    if (mod_start_cnt !== 21) begin err_cnt++; $display("FAIL sat_wide_start: got %0d want 21", mod_start_cnt); end
    vec_cnt++;
    if (mod_busy_cycles !== 24) begin err_cnt++; $display("FAIL sat_wide_busy: got %0d want 24", mod_busy_cycles); end
    vec_cnt++;
    if (s_start !== 3'd7) begin err_cnt++; $display("FAIL sat_start: got %0d want 7", s_start); end
    vec_cnt++;
    if (s_busy_cyc !== 3'd7) begin err_cnt++; $display("FAIL sat_busy: got %0d want 7", s_busy_cyc); end
    vec_cnt++;
  endtask

  initial begin
    test_reset();
    test_single_call();
    test_backpressure();
    test_back_to_back();
    test_loop();
    test_quit_at_end();
    test_stall();
    test_freeze();
    test_reset_mid_op();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
